seq_detector_prog: RTL and testbench

- Programmable, parametrised Mealy serial sequence detector. Next generation of the team's fixed-pattern FSM detectors.
- Detects a runtime-loadable bit pattern of 1..MAX_LEN bits on a 1-bit qualified input stream.
- Has a selectable overlap / non-overlap mode and a saturating match counter.
- Sits between a serial bit source and control logic that consumes a match pulse or count.

---
 rtl/seq_detector_prog.sv | 111 +++++++++++
 tb/tb_seq_detector_prog.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_prog.sv
// Programmable Mealy serial sequence detector: runtime-loadable pattern of 1..MAX_LEN bits,
// selectable overlap mode, saturating match counter and a registered copy of the match pulse.
module seq_detector_prog #(
   parameter int                 MAX_LEN     = 8,
   parameter int                 CNT_W       = 8,
   parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'b0000_1011,
   parameter int                 RST_LEN     = 4,
   localparam int                LW          = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   input  logic               inp,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LW-1:0]      cfg_len,
   input  logic               overlap_en,
   input  logic               cnt_clr,
   output logic               out,
   output logic               out_q,
   output logic [CNT_W-1:0]   match_cnt
);

   logic [MAX_LEN-1:0] pat_q, pat_d;
   logic [LW-1:0]      len_q, len_d;
   // The oldest history bit is shifted out before it can ever be compared, so only
   // MAX_LEN-1 bits are stored; the incoming bit completes the window.
   logic [MAX_LEN-2:0] hist_q, hist_d;
   logic [LW-1:0]      fill_q, fill_d;
   logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;

   logic [MAX_LEN-1:0] cand;
   logic [MAX_LEN-1:0] len_mask;
   logic [LW:0]        fill_p1;
   logic [LW-1:0]      cfg_len_clamped;
   logic               fill_reached;
   logic               pattern_hit;
   logic               out_d;

   assign cand            = {hist_q, inp};
   assign fill_p1         = {1'b0, fill_q} + (LW + 1)'(1);
   assign fill_reached    = fill_p1 >= {1'b0, len_q};
   assign cfg_len_clamped = (cfg_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cfg_len;

   // NOTE: every variable written in an always_comb gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      len_mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         len_mask[i] = (i < int'(len_q));
      end
   end

   assign pattern_hit = (((cand ^ pat_q) & len_mask) == '0);

   // Mealy output: the completing bit raises out in its own cycle; forced low during reset.
   assign out_d = reset & in_valid & ~cfg_load & (len_q != '0) & fill_reached & pattern_hit;
   assign out   = out_d;

   always_comb begin
      pat_d  = pat_q;
      len_d  = len_q;
      hist_d = hist_q;
      fill_d = fill_q;
      if (cfg_load) begin
         pat_d  = cfg_pattern;
         len_d  = cfg_len_clamped;
         hist_d = '0;
         fill_d = '0;
      end else if (in_valid) begin
         hist_d = cand[MAX_LEN-2:0];
         if (out_d && !overlap_en) begin
            fill_d = '0;
         end else if (fill_q < len_q) begin
            fill_d = fill_p1[LW-1:0];
         end
      end
   end

   always_comb begin
      match_cnt_d = match_cnt_q;
      if (cnt_clr) begin
         match_cnt_d = out_d ? CNT_W'(1) : '0;
      end else if (out_d && !(&match_cnt_q)) begin
         match_cnt_d = match_cnt_q + CNT_W'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the
   // pre-edge values computed above, independent of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pat_q       <= RST_PATTERN;
         len_q       <= LW'(RST_LEN);
         hist_q      <= '0;
         fill_q      <= '0;
         out_q       <= 1'b0;
         match_cnt_q <= '0;
      end else begin
         pat_q       <= pat_d;
         len_q       <= len_d;
         hist_q      <= hist_d;
         fill_q      <= fill_d;
         out_q       <= out_d;
         match_cnt_q <= match_cnt_d;
      end
   end

   assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Self-checking bench for seq_detector_prog: directed vector table, hand-written corner
// sequences, then random traffic against a queue-based reference model. Two builds (CNT_W 8 and 4).
module tb_seq_detector_prog;

   localparam int MAX_LEN = 8;
   localparam int LW      = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic           in_valid, inp, cfg_load, overlap_en, cnt_clr;
   logic [7:0]     cfg_pattern;
   logic [LW-1:0]  cfg_len;
   logic           out8, out_q8, out4, out_q4;
   logic [7:0]     cnt8;
   logic [3:0]     cnt4;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   seq_detector_prog #(.MAX_LEN(8), .CNT_W(8)) dut8 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .inp(inp), .cfg_load(cfg_load),
      .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .overlap_en(overlap_en), .cnt_clr(cnt_clr),
      .out(out8), .out_q(out_q8), .match_cnt(cnt8)
   );

   seq_detector_prog #(.MAX_LEN(8), .CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .inp(inp), .cfg_load(cfg_load),
      .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .overlap_en(overlap_en), .cnt_clr(cnt_clr),
      .out(out4), .out_q(out_q4), .match_cnt(cnt4)
   );

   // ---------------- reference model: bits received since the last restart ----------------
   logic       hist_m[$];
   logic [7:0] pat_m;
   int         len_m;
   int         cnt8_m, cnt4_m;
   logic       outq_m;

   function automatic void model_reset();
      hist_m.delete();
      pat_m  = 8'b0000_1011;
      len_m  = 4;
      cnt8_m = 0;
      cnt4_m = 0;
      outq_m = 1'b0;
   endfunction

   // A match means: the last len_m received bits, oldest first, spell pat_m[len_m-1] .. pat_m[0].
   function automatic logic model_match(input logic v, input logic b, input logic ld);
      logic seq[$];
      if (!v || ld || len_m == 0) return 1'b0;
      seq = hist_m;
      seq.push_back(b);
      if (seq.size() < len_m) return 1'b0;
      for (int k = 0; k < len_m; k++) begin
         if (seq[seq.size() - 1 - k] != pat_m[k]) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic void model_update(input logic v, input logic b, input logic ld,
                                        input logic [7:0] p, input logic [LW-1:0] l,
                                        input logic ov, input logic clr, input logic m);
      if (ld) begin
         pat_m = p;
         len_m = (int'(l) > MAX_LEN) ? MAX_LEN : int'(l);
         hist_m.delete();
      end else if (v) begin
         hist_m.push_back(b);
         if (hist_m.size() > MAX_LEN) void'(hist_m.pop_front());
         if (m && !ov) hist_m.delete();
      end
      if (clr) begin
         cnt8_m = m ? 1 : 0;
         cnt4_m = m ? 1 : 0;
      end else if (m) begin
         cnt8_m = (cnt8_m == 255) ? 255 : cnt8_m + 1;
         cnt4_m = (cnt4_m == 15) ? 15 : cnt4_m + 1;
      end
      outq_m = m;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // One clock cycle: drive at posedge+1, compare at negedge, advance model after posedge.
   task automatic step(input logic v, input logic b, input logic ld, input logic [7:0] p,
                       input logic [LW-1:0] l, input logic ov, input logic clr,
                       output logic got_out, output logic [7:0] got_cnt);
      logic m;
      in_valid = v; inp = b; cfg_load = ld; cfg_pattern = p; cfg_len = l;
      overlap_en = ov; cnt_clr = clr;
      @(negedge clk);
      m = model_match(v, b, ld);
      got_out = out8;
      check("out", {31'b0, out8}, {31'b0, m});
      check("out_w4", {31'b0, out4}, {31'b0, m});
      check("out_q", {31'b0, out_q8}, {31'b0, outq_m});
      check("out_q_w4", {31'b0, out_q4}, {31'b0, outq_m});
      check("match_cnt", {24'b0, cnt8}, cnt8_m);
      check("match_cnt_w4", {28'b0, cnt4}, cnt4_m);
      @(posedge clk);
      #1;
      model_update(v, b, ld, p, l, ov, clr, m);
      got_cnt = cnt8;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct packed {
      logic           v, b, ld;
      logic [7:0]     p;
      logic [LW-1:0]  l;
      logic           ov, clr;
      logic           exp_out;
      logic [7:0]     exp_cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic void add_bit(input logic b, input logic ov, input logic eo, input int ec);
      vecs.push_back('{1'b1, b, 1'b0, 8'h00, 4'd0, ov, 1'b0, eo, 8'(ec)});
   endfunction

   function automatic void add_gap(input logic b, input int ec);
      vecs.push_back('{1'b0, b, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0, 8'(ec)});
   endfunction

   // Load with a clear; a valid 1 is presented the same cycle and must be dropped.
   function automatic void add_load(input logic [7:0] p, input logic [LW-1:0] l);
      vecs.push_back('{1'b1, 1'b1, 1'b1, p, l, 1'b1, 1'b1, 1'b0, 8'd0});
   endfunction

   initial begin
      logic       got_o;
      logic [7:0] got_c;
      logic       ov_r;
      logic [7:0] rp;
      logic [LW-1:0] rl;

      reset = 1'b0; in_valid = 1'b0; inp = 1'b0; cfg_load = 1'b0;
      cfg_pattern = '0; cfg_len = '0; overlap_en = 1'b1; cnt_clr = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_out", {31'b0, out8}, 32'd0);
      check("reset_out_q", {31'b0, out_q8}, 32'd0);
      check("reset_cnt", {24'b0, cnt8}, 32'd0);
      reset = 1'b1;

      // 1011 overlapping, then non-overlapping
      add_bit(1, 1, 0, 0); add_bit(0, 1, 0, 0); add_bit(1, 1, 0, 0); add_bit(1, 1, 1, 1);
      add_bit(0, 1, 0, 1); add_bit(1, 1, 0, 1); add_bit(1, 1, 1, 2); add_gap(0, 2);
      add_load(8'h0B, 4'd4);
      add_bit(1, 0, 0, 0); add_bit(0, 0, 0, 0); add_bit(1, 0, 0, 0); add_bit(1, 0, 1, 1);
      add_bit(0, 0, 0, 1); add_bit(1, 0, 0, 1); add_bit(1, 0, 0, 1);
      // 111, len 3
      add_load(8'h07, 4'd3);
      add_bit(1, 1, 0, 0); add_bit(1, 1, 0, 0); add_bit(1, 1, 1, 1); add_bit(1, 1, 1, 2);
      add_bit(1, 1, 1, 3);
      add_load(8'h07, 4'd3);
      add_bit(1, 0, 0, 0); add_bit(1, 0, 0, 0); add_bit(1, 0, 1, 1); add_bit(1, 0, 0, 1);
      add_bit(1, 0, 0, 1); add_bit(1, 0, 1, 2);
      // valid gaps with toggling data
      add_load(8'h0B, 4'd4);
      add_bit(1, 1, 0, 0); add_gap(0, 0); add_gap(1, 0); add_bit(0, 1, 0, 0);
      add_gap(1, 0); add_gap(0, 0); add_bit(1, 1, 0, 0); add_gap(0, 0); add_gap(1, 0);
      add_bit(1, 1, 1, 1);
      // len 0 never matches
      add_load(8'h00, 4'd0);
      add_bit(0, 1, 0, 0); add_bit(0, 1, 0, 0); add_bit(1, 1, 0, 0); add_bit(0, 1, 0, 0);
      // len 15 clamps to 8
      add_load(8'hA5, 4'd15);
      add_bit(1, 1, 0, 0); add_bit(0, 1, 0, 0); add_bit(1, 1, 0, 0); add_bit(0, 1, 0, 0);
      add_bit(0, 1, 0, 0); add_bit(1, 1, 0, 0); add_bit(0, 1, 0, 0); add_bit(1, 1, 1, 1);
      add_bit(0, 1, 0, 1); add_bit(1, 1, 0, 1);

      foreach (vecs[i]) begin
         step(vecs[i].v, vecs[i].b, vecs[i].ld, vecs[i].p, vecs[i].l, vecs[i].ov, vecs[i].clr,
              got_o, got_c);
         check($sformatf("vec%0d_out", i), {31'b0, got_o}, {31'b0, vecs[i].exp_out});
         check($sformatf("vec%0d_cnt", i), {24'b0, got_c}, {24'b0, vecs[i].exp_cnt});
      end

      // Saturation: len-1 pattern '1', 20 matches
      step(1, 1, 1, 8'h01, 4'd1, 1, 1, got_o, got_c);
      for (int i = 0; i < 20; i++) step(1, 1, 0, 8'h00, 4'd0, 1, 0, got_o, got_c);
      check("sat_cnt8", {24'b0, cnt8}, 32'd20);
      check("sat_cnt4", {28'b0, cnt4}, 32'd15);
      step(1, 1, 0, 8'h00, 4'd0, 1, 1, got_o, got_c);
      check("clr_with_match_cnt8", {24'b0, cnt8}, 32'd1);
      check("clr_with_match_cnt4", {28'b0, cnt4}, 32'd1);

      // Reset mid-sequence with a match pending on the bus
      step(1, 1, 1, 8'h06, 4'd4, 1, 0, got_o, got_c);
      step(1, 0, 0, 8'h00, 4'd0, 1, 0, got_o, got_c);
      step(1, 1, 0, 8'h00, 4'd0, 1, 0, got_o, got_c);
      step(1, 1, 0, 8'h00, 4'd0, 1, 0, got_o, got_c);
      in_valid = 1'b1; inp = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
      @(negedge clk);
      check("pre_reset_out", {31'b0, out8}, 32'd1);
      check("pre_reset_cnt", {24'b0, cnt8}, 32'd1);
      #1 reset = 1'b0;
      #1;
      check("mid_reset_out", {31'b0, out8}, 32'd0);
      check("mid_reset_out_q", {31'b0, out_q8}, 32'd0);
      check("mid_reset_cnt8", {24'b0, cnt8}, 32'd0);
      check("mid_reset_cnt4", {28'b0, cnt4}, 32'd0);
      in_valid = 1'b0;
      #1 reset = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      step(1, 0, 0, 8'h00, 4'd0, 1, 0, got_o, got_c);
      check("post_reset_bit0", {31'b0, got_o}, 32'd0);
      step(1, 1, 0, 8'h00, 4'd0, 1, 0, got_o, got_c);
      step(1, 0, 0, 8'h00, 4'd0, 1, 0, got_o, got_c);
      step(1, 1, 0, 8'h00, 4'd0, 1, 0, got_o, got_c);
      step(1, 1, 0, 8'h00, 4'd0, 1, 0, got_o, got_c);
      check("post_reset_1011", {31'b0, got_o}, 32'd1);

      // Random traffic against the model
      ov_r = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         rp = 8'($urandom);
         rl = ($urandom_range(9) == 0) ? LW'($urandom_range(15)) : LW'($urandom_range(4, 1));
         if ($urandom_range(19) == 0) ov_r = ~ov_r;
         step(($urandom_range(3) != 0), 1'($urandom_range(1)), ($urandom_range(99) < 3),
              rp, rl, ov_r, ($urandom_range(199) == 0), got_o, got_c);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
